// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage with registered in_ready and out_data.
// Also keeps saturating stall and flush statistics.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        occ_q, occ_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            S_EMPTY: begin
                if (in_xfer) begin
                    state_d = S_ONE;
                    main_d  = in_data;
                end
            end
            S_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (in_xfer) begin
                    state_d = S_FULL;
                    skid_d  = in_data;
                end else if (out_xfer) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (out_xfer) begin
                    state_d = S_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Flush wins over any handshake; held data simply becomes stale.
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_comb begin
        in_ready_d  = (state_d != S_FULL);
        out_valid_d = (state_d != S_EMPTY);
        occ_d       = 2'd0;
        unique case (state_d)
            S_EMPTY: occ_d = 2'd0;
            S_ONE:   occ_d = 2'd1;
            S_FULL:  occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (out_valid_q && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (flush && (occ_q != 2'd0) && (flush_q != '1)) begin
            flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
            stall_q     <= '0;
            flush_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue scoreboard plus directed and random traffic.
// Counters use CNT_W=4 so saturation is reachable.
module tb_pipe_stage_skid;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    pipe_stage_skid #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] mq[$];
    int            m_stall = 0;
    int            m_flush = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic cycle(input logic rn, input logic fl, input logic iv,
                         input logic [DW-1:0] id, input logic ordy);
        int            n;
        bit            ixf;
        bit            oxf;
        logic [DW-1:0] exp;
        n   = mq.size();
        ixf = iv && (n < 2);
        oxf = ordy && (n > 0);
        rst_n     = rn;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        if (!rn) begin
            mq.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (oxf) begin
                exp = mq.pop_front();
                chk("deliver", {16'd0, out_data}, {16'd0, exp});
            end
            if (n > 0 && !ordy && m_stall < 15) m_stall++;
            if (fl && n > 0 && m_flush < 15) m_flush++;
            if (fl) mq.delete();
            else if (ixf) mq.push_back(id);
        end
        @(posedge clk);
        #1;
        chk("occ", {30'd0, occupancy}, mq.size());
        chk("in_rdy", {31'd0, in_ready}, {31'd0, mq.size() < 2});
        chk("out_vld", {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk("stall", {28'd0, stall_cnt}, m_stall);
        chk("flush", {28'd0, flush_cnt}, m_flush);
        if (mq.size() > 0) chk("head", {16'd0, out_data}, {16'd0, mq[0]});
        if (!rn) chk("rst_data", {16'd0, out_data}, 32'd0);
    endtask

    initial begin
        int saved;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        cycle(0, 0, 0, 16'h0, 0);
        cycle(0, 1, 1, 16'hdead, 1);

        for (int i = 1; i <= 20; i++) cycle(1, 0, 1, DW'(i), 1);
        cycle(1, 0, 0, 16'h0, 1);

        cycle(1, 0, 1, 16'h00a0, 0);
        cycle(1, 0, 1, 16'h00b0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 16'h0bad, 0);
        cycle(1, 0, 0, 16'h0, 1);
        cycle(1, 0, 0, 16'h0, 1);

        cycle(1, 0, 1, 16'h0011, 0);
        cycle(1, 0, 1, 16'h0022, 0);
        cycle(1, 1, 1, 16'h00c0, 0);
        cycle(1, 0, 0, 16'h0, 1);

        saved = m_flush;
        cycle(1, 1, 0, 16'h0, 1);
        chk("flush_empty", {28'd0, flush_cnt}, saved);

        cycle(0, 0, 0, 16'h0, 0);
        cycle(1, 0, 1, 16'h0123, 0);
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 16'h0, 0);
        chk("stall_sat", {28'd0, stall_cnt}, 32'd15);

        cycle(1, 0, 1, 16'h0456, 0);
        cycle(0, 0, 1, 16'h0789, 1);
        cycle(1, 0, 1, 16'h00d0, 0);
        chk("d_out", {16'd0, out_data}, 32'h00d0);
        cycle(1, 0, 0, 16'h0, 1);

        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)),
                  DW'($urandom),
                  ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
